alu: RTL and testbench

Registered, parameterised arithmetic/logic unit on the single system clock. On each clock edge where `Enable` is high, it evaluates one of 16 operations on operands `A` and `B`. The operation is selected by `ALU_FUN`. The result is captured into `ALU_OUT` and `OUT_VALID` is raised. It serves as the datapath execution unit driven by the system controller/register file.

---
 rtl/alu.sv | 95 +++++++++
 tb/tb_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 16-function arithmetic/logic unit: one-cycle latency, result and
// valid flag held between enabled edges, cleared by asynchronous active-low reset.
module alu #(
    parameter int unsigned OPRND_WIDTH = 8,
    parameter int unsigned OUT_WIDTH   = 2 * OPRND_WIDTH,
    parameter int unsigned CTRL_WIDTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Enable,
    input  logic [OPRND_WIDTH-1:0] A,
    input  logic [OPRND_WIDTH-1:0] B,
    input  logic [CTRL_WIDTH-1:0]  ALU_FUN,
    output logic [OUT_WIDTH-1:0]   ALU_OUT,
    output logic                   OUT_VALID
);

    typedef enum logic [CTRL_WIDTH-1:0] {
        OP_ADD  = CTRL_WIDTH'(0),
        OP_SUB  = CTRL_WIDTH'(1),
        OP_MUL  = CTRL_WIDTH'(2),
        OP_DIV  = CTRL_WIDTH'(3),
        OP_AND  = CTRL_WIDTH'(4),
        OP_OR   = CTRL_WIDTH'(5),
        OP_NAND = CTRL_WIDTH'(6),
        OP_NOR  = CTRL_WIDTH'(7),
        OP_NOP  = CTRL_WIDTH'(8),
        OP_EQ   = CTRL_WIDTH'(9),
        OP_GT   = CTRL_WIDTH'(10),
        OP_LT   = CTRL_WIDTH'(11),
        OP_SRA1 = CTRL_WIDTH'(12),
        OP_SLA1 = CTRL_WIDTH'(13),
        OP_SRB1 = CTRL_WIDTH'(14),
        OP_SLB1 = CTRL_WIDTH'(15)
    } alu_op_e;

    alu_op_e              op;
    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH-1:0] result;
    logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
    logic                 out_valid_q, out_valid_d;

    assign op    = alu_op_e'(ALU_FUN);
    assign a_ext = OUT_WIDTH'(A);
    assign b_ext = OUT_WIDTH'(B);

    // Everything is evaluated at OUT_WIDTH so carries, borrows, the full
    // product and shifted-out bits survive, and inverted ops fill the top with ones.
    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_DIV:  result = (B == '0) ? '0 : a_ext / b_ext;
            OP_AND:  result = a_ext & b_ext;
            OP_OR:   result = a_ext | b_ext;
            OP_NAND: result = ~(a_ext & b_ext);
            OP_NOR:  result = ~(a_ext | b_ext);
            OP_NOP:  result = '0;
            OP_EQ:   result = (A == B) ? OUT_WIDTH'(1) : '0;
            OP_GT:   result = (A >  B) ? OUT_WIDTH'(2) : '0;
            OP_LT:   result = (A <  B) ? OUT_WIDTH'(3) : '0;
            OP_SRA1: result = a_ext >> 1;
            OP_SLA1: result = a_ext << 1;
            OP_SRB1: result = b_ext >> 1;
            OP_SLB1: result = b_ext << 1;
            default: result = '0;
        endcase
    end

    always_comb begin
        alu_out_d   = alu_out_q;
        out_valid_d = out_valid_q;
        if (Enable) begin
            alu_out_d   = result;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ALU_OUT   = alu_out_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: one task per feature, hand-computed
// expected values, outputs sampled on the falling clock edge.
module tb_alu;

    logic        CLK;
    logic        RST;
    logic        Enable;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alu #(.OPRND_WIDTH(8), .OUT_WIDTH(16), .CTRL_WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Enable    (Enable),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle Enable pulse, returning at the falling edge two cycles after issue.
    task automatic pulse_op(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        ALU_FUN = fun; A = a; B = b; Enable = 1'b1;
        @(negedge CLK);
        Enable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_initial();
        #1;
        n_checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: out=%h valid=%b, want out=0000 valid=0", ALU_OUT, OUT_VALID);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: out=%h valid=%b, want out=0000 valid=0", ALU_OUT, OUT_VALID);
        end
    endtask

    task automatic test_arith();
        logic [3:0]  f [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd3};
        logic [7:0]  a [6] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h03, 8'h55};
        logic [7:0]  b [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h05, 8'h00};
        logic [15:0] e [6] = '{16'h0110, 16'h00D0, 16'h1E00, 16'h0007, 16'hFFFE, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            pulse_op(f[i], a[i], b[i]);
            n_checks++;
            if (ALU_OUT !== e[i] || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL arith[%0d] op=%0d a=%h b=%h: out=%h valid=%b, want out=%h valid=1",
                         i, f[i], a[i], b[i], ALU_OUT, OUT_VALID, e[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0]  f [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        logic [15:0] e [5] = '{16'h0088, 16'h00EE, 16'hFF77, 16'hFF11, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            pulse_op(f[i], 8'hCC, 8'hAA);
            n_checks++;
            if (ALU_OUT !== e[i] || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL logic op=%0d: out=%h valid=%b, want out=%h valid=1",
                         f[i], ALU_OUT, OUT_VALID, e[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0]  f [7] = '{4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd9, 4'd11};
        logic [7:0]  a [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h09, 8'h04, 8'h09, 8'h09};
        logic [7:0]  b [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h04, 8'h09, 8'h04, 8'h04};
        logic [15:0] e [7] = '{16'd1, 16'd0, 16'd0, 16'd2, 16'd3, 16'd0, 16'd0};
        for (int i = 0; i < 7; i++) begin
            pulse_op(f[i], a[i], b[i]);
            n_checks++;
            if (ALU_OUT !== e[i] || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL compare[%0d] op=%0d a=%h b=%h: out=%h, want %h",
                         i, f[i], a[i], b[i], ALU_OUT, e[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  f [4] = '{4'd12, 4'd13, 4'd14, 4'd15};
        logic [15:0] e [4] = '{16'h0040, 16'h0102, 16'h0061, 16'h0186};
        for (int i = 0; i < 4; i++) begin
            pulse_op(f[i], 8'h81, 8'hC3);
            n_checks++;
            if (ALU_OUT !== e[i] || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL shift op=%0d: out=%h, want %h", f[i], ALU_OUT, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  f [3] = '{4'd0, 4'd2, 4'd1};
        logic [7:0]  a [3] = '{8'h12, 8'hFF, 8'h00};
        logic [7:0]  b [3] = '{8'h34, 8'hFF, 8'h01};
        logic [15:0] e [3] = '{16'h0046, 16'hFE01, 16'hFFFF};
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            ALU_FUN = f[i]; A = a[i]; B = b[i]; Enable = 1'b1;
            @(negedge CLK);
            n_checks++;
            if (ALU_OUT !== e[i] || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: out=%h valid=%b, want out=%h valid=1",
                         i, ALU_OUT, OUT_VALID, e[i]);
            end
        end
        Enable = 1'b0;
    endtask

    task automatic test_hold();
        pulse_op(4'd0, 8'h10, 8'h05);
        A = 8'hFF; B = 8'h01; ALU_FUN = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            A = A - 8'd3; ALU_FUN = ALU_FUN + 4'd1;
            n_checks++;
            if (ALU_OUT !== 16'h0015 || OUT_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL hold[%0d]: out=%h valid=%b, want out=0015 valid=1", i, ALU_OUT, OUT_VALID);
            end
        end
    endtask

    task automatic test_reset_midstream();
        pulse_op(4'd2, 8'h0F, 8'h0F);
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h valid=%b, want out=0000 valid=0", ALU_OUT, OUT_VALID);
        end
        Enable = 1'b1; ALU_FUN = 4'd0;
        @(negedge CLK);
        n_checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: out=%h valid=%b, want out=0000 valid=0", ALU_OUT, OUT_VALID);
        end
        Enable = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (ALU_OUT !== 16'h0000 || OUT_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h valid=%b, want out=0000 valid=0", ALU_OUT, OUT_VALID);
        end
        pulse_op(4'd9, 8'h33, 8'h33);
        n_checks++;
        if (ALU_OUT !== 16'h0001 || OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recover: out=%h valid=%b, want out=0001 valid=1", ALU_OUT, OUT_VALID);
        end
    endtask

    initial begin
        RST = 1'b0; Enable = 1'b0; A = '0; B = '0; ALU_FUN = '0;
        test_reset_initial();
        test_arith();
        test_logic();
        test_compare();
        test_shift();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
